// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial add/subtract unit.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sa_state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_adder_fa.sv
// Single-bit full adder cell built from gate primitives.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic ab_xor_s;
    logic ab_and_s;
    logic cin_prop_s;

    xor g_x0 (ab_xor_s, a, b);
    xor g_x1 (sum, ab_xor_s, cin);
    and g_a0 (ab_and_s, a, b);
    and g_a1 (cin_prop_s, cin, ab_xor_s);
    or  g_o0 (cout, ab_and_s, cin_prop_s);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial add/subtract unit: one full-adder cell plus carry flop, LSB first,
// with a start/done handshake and back-to-back acceptance from DONE.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int SUB_EN = 1
) (
    input  logic             hz100,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    sa_state_t        state_r;
    sa_state_t        state_next_s;
    logic             accept_s;
    logic             step_s;
    logic             last_s;
    logic             sub_s;

    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic             carry_r;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] result_r;
    logic [WIDTH-1:0] result_next_s;

    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             overflow_r;

    logic             fa_sum_s;
    logic             fa_cout_s;

    // Subtraction is only honoured when the parameter enables it.
    assign sub_s = (SUB_EN != 0) ? (mode == MODE_SUB) : 1'b0;

    full_adder u_fa (
        .a    (a_sh_r[0]),
        .b    (b_sh_r[0]),
        .cin  (carry_r),
        .sum  (fa_sum_s),
        .cout (fa_cout_s)
    );

    // Each result bit lands at the position of the bit currently being processed.
    assign result_next_s = result_r | (WIDTH'(fa_sum_s) << count_r);

    // State register.
    always_ff @(posedge hz100) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode and datapath enables.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        step_s       = 1'b0;
        last_s       = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    state_next_s = SHIFT;
                    accept_s     = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHIFT: begin
                step_s = 1'b1;
                if (count_r == LAST_BIT) begin
                    state_next_s = DONE;
                    last_s       = 1'b1;
                end else begin
                    state_next_s = SHIFT;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Operand capture, serial add step and result publication on entry to DONE.
    always_ff @(posedge hz100) begin
        if (reset) begin
            a_sh_r     <= '0;
            b_sh_r     <= '0;
            carry_r    <= 1'b0;
            count_r    <= '0;
            result_r   <= '0;
            sum_r      <= '0;
            cout_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else if (accept_s) begin
            a_sh_r   <= a;
            b_sh_r   <= sub_s ? ~b : b;
            carry_r  <= sub_s ? 1'b1 : cin;
            count_r  <= '0;
            result_r <= '0;
        end else if (step_s) begin
            a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
            b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
            carry_r  <= fa_cout_s;
            result_r <= result_next_s;
            if (last_s) begin
                // carry_r still holds the carry into the MSB here.
                count_r    <= count_r;
                sum_r      <= result_next_s;
                cout_r     <= fa_cout_s;
                overflow_r <= carry_r ^ fa_cout_s;
            end else begin
                count_r <= count_r + CW'(1);
            end
        end
    end

    // Handshake flags registered from the next state so they never overlap.
    always_ff @(posedge hz100) begin
        if (reset) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_next_s == SHIFT);
            done_r <= (state_next_s == DONE);
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign sum      = sum_r;
    assign cout     = cout_r;
    assign overflow = overflow_r;

endmodule
